// File: rtl/pos_to_board_if.sv
// pos_to_board_if: beat-in / board-out handshake bundle; out_dup exists only with POS_TO_BOARD_DUP_DETECT_EN
interface pos_to_board_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_pos;
  logic [1:0]  in_op;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_board;
  logic [6:0]  out_count;
`ifdef POS_TO_BOARD_DUP_DETECT_EN
  logic        out_dup;
  modport master (output in_valid, in_pos, in_op, in_last, out_ready,
                  input  in_ready, out_valid, out_board, out_count, out_dup);
  modport slave  (input  in_valid, in_pos, in_op, in_last, out_ready,
                  output in_ready, out_valid, out_board, out_count, out_dup);
`else
  modport master (output in_valid, in_pos, in_op, in_last, out_ready,
                  input  in_ready, out_valid, out_board, out_count);
  modport slave  (input  in_valid, in_pos, in_op, in_last, out_ready,
                  output in_ready, out_valid, out_board, out_count);
`endif
endinterface

// File: rtl/pos_to_board.sv
// pos_to_board: accumulates framed 6-bit square beats into a 64-bit board; optional POS_TO_BOARD_DUP_DETECT_EN adds a sticky duplicate flag
module pos_to_board (
  input logic            i_clk,
  input logic            i_rst,
  pos_to_board_if.slave  bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [63:0] r_board;
  logic [6:0]  r_count;
  logic [63:0] w_onehot;
  logic [63:0] w_next;
  logic        w_take;
  logic        w_give;
  assign w_take   = bus.in_valid && r_state == ACCUM;
  assign w_give   = bus.out_ready && r_state == HOLD;
  assign w_onehot = 64'd1 << bus.in_pos;
  // board after applying this beat's op; reserved op leaves it untouched
  always_comb
    w_next = bus.in_op == 2'b00 ? r_board | w_onehot :
             bus.in_op == 2'b01 ? r_board & ~w_onehot :
             bus.in_op == 2'b10 ? r_board ^ w_onehot : r_board;
  // frame FSM: accumulate until the last beat, then hold the result until taken
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_board     <= '0;
      r_count     <= '0;
    end else if (w_take) begin
      r_board <= w_next;
      r_count <= r_count + {6'd0, r_count != 7'd127};
      if (bus.in_last) begin
        r_state     <= HOLD;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b1;
      end
    end else if (w_give) begin
      r_state     <= ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_board     <= '0;
      r_count     <= '0;
    end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_board = r_board;
  assign bus.out_count = r_count;
`ifdef POS_TO_BOARD_DUP_DETECT_EN
  logic r_dup;
  logic w_hit;
  assign w_hit = bus.in_op == 2'b11 ||
                 (bus.in_op == 2'b00 && r_board[bus.in_pos]) ||
                 (bus.in_op == 2'b01 && !r_board[bus.in_pos]);
  // sticky per-frame flag for redundant set/clear or reserved ops, judged on the pre-beat board
  always_ff @(posedge i_clk)
    if (i_rst || w_give) r_dup <= 1'b0;
    else if (w_take && w_hit) r_dup <= 1'b1;
  assign bus.out_dup = r_dup;
`endif
endmodule

// File: tb/tb_pos_to_board.sv
// tb_pos_to_board: table-driven frames with a scoreboard queue, plus backpressure, mid-frame reset and saturation sequences
module tb_pos_to_board;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pos_to_board_if bus();
  pos_to_board dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  typedef struct {
    logic [5:0]  pos;
    logic [1:0]  op;
    logic        last;
    logic [63:0] eb;
    logic [6:0]  ec;
    logic        ed;
  } vec_t;
  typedef struct {
    logic [63:0] b;
    logic [6:0]  c;
    logic        d;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[12];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [63:0] b, input logic [6:0] c, input logic d);
    exp_t e;
    e.b = b;
    e.c = c;
    e.d = d;
    sb.push_back(e);
  endtask
  task automatic beat(input logic [5:0] p, input logic [1:0] o, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_pos   = p;
    bus.in_op    = o;
    bus.in_last  = l;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    int n = 0;
    exp_t e;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd0);
    if (sb.size() == 0) chk({nm, "_sb_empty"}, 64'd0, 64'd1);
    else begin
      e = sb.pop_front();
      chk({nm, "_board"}, bus.out_board, e.b);
      chk({nm, "_count"}, 64'(bus.out_count), 64'(e.c));
`ifdef POS_TO_BOARD_DUP_DETECT_EN
      chk({nm, "_dup"}, 64'(bus.out_dup), 64'(e.d));
`endif
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask
  initial begin
    tbl[0]  = '{6'd0,  2'b00, 1'b0, 64'd0, 7'd0, 1'b0};
    tbl[1]  = '{6'd63, 2'b00, 1'b0, 64'd0, 7'd0, 1'b0};
    tbl[2]  = '{6'd27, 2'b00, 1'b1, 64'h8000000008000001, 7'd3, 1'b0};
    tbl[3]  = '{6'd5,  2'b10, 1'b0, 64'd0, 7'd0, 1'b0};
    tbl[4]  = '{6'd5,  2'b10, 1'b0, 64'd0, 7'd0, 1'b0};
    tbl[5]  = '{6'd6,  2'b00, 1'b1, 64'h40, 7'd3, 1'b0};
    tbl[6]  = '{6'd10, 2'b01, 1'b0, 64'd0, 7'd0, 1'b0};
    tbl[7]  = '{6'd20, 2'b11, 1'b1, 64'd0, 7'd2, 1'b1};
    tbl[8]  = '{6'd63, 2'b10, 1'b1, 64'h8000000000000000, 7'd1, 1'b0};
    tbl[9]  = '{6'd1,  2'b00, 1'b0, 64'd0, 7'd0, 1'b0};
    tbl[10] = '{6'd1,  2'b00, 1'b1, 64'h2, 7'd2, 1'b1};
    tbl[11] = '{6'd40, 2'b01, 1'b1, 64'd0, 7'd1, 1'b1};
    bus.in_valid  = 1'b0;
    bus.in_pos    = '0;
    bus.in_op     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_board", bus.out_board, 64'd0);
    chk("rst_count", 64'(bus.out_count), 64'd0);
`ifdef POS_TO_BOARD_DUP_DETECT_EN
    chk("rst_dup", 64'(bus.out_dup), 64'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].last) push(tbl[i].eb, tbl[i].ec, tbl[i].ed);
      beat(tbl[i].pos, tbl[i].op, tbl[i].last);
      if (tbl[i].last) drain($sformatf("tbl%0d", i));
    end
    bus.out_ready = 1'b0;
    beat(6'd9, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pos   = 6'd1;
      bus.in_op    = 2'b00;
      bus.in_last  = 1'b1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_board", bus.out_board, 64'h200);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    push(64'h200, 7'd1, 1'b0);
    drain("bp_frame");
    push(64'h2, 7'd1, 1'b0);
    beat(6'd1, 2'b00, 1'b1);
    drain("bp_next");
    beat(6'd2, 2'b00, 1'b0);
    beat(6'd3, 2'b00, 1'b0);
    beat(6'd4, 2'b00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_board", bus.out_board, 64'd0);
    chk("mid_rst_count", 64'(bus.out_count), 64'd0);
    push(64'h80, 7'd1, 1'b0);
    beat(6'd7, 2'b00, 1'b1);
    drain("after_rst");
    push(64'h2, 7'd127, 1'b1);
    for (int i = 0; i < 130; i++) beat(6'd1, 2'b00, i == 129);
    drain("sat");
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
